pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage RISC-V pipeline.
- Drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three hazard classes: load-use data hazards, taken-branch/jump redirects, and instruction/data memory wait states.
- Counts stall and flush events for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/hazard_perf_counters.sv | 54 +++++
 rtl/pipeline_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the 5-stage pipeline sequencing logic: hazard FSM states
// and the per-register enable/flush bundle used by the pipeline registers.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_IMISS    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall/flush performance counters plus the dmem wait-state watchdog
// (saturating wait counter and sticky timeout flag).
module hazard_perf_counters #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             dwait_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             dmem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    stall_cnt_d = stall_inc ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = flush_inc ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    wait_cnt_d  = '0;
    if (dwait_stall) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    // Flag as soon as the saturation value is reached; never cleared except by reset.
    timeout_d = timeout_q | (dwait_stall && (wait_cnt_d == WAIT_MAX));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign dmem_timeout = timeout_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencing for the 5-stage pipeline: prioritises dmem freeze,
// redirects, load-use bubbles and fetch stalls into register enables/flushes.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  imem_ready,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic                  dmem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  hz_state_t  state_q, state_d;
  logic       redirect_pend_q, redirect_pend_d;
  logic       load_use, dmem_stall, redir_act, dwait_stall, flush_inc;
  pipe_ctrl_t ctrl;

  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    // The cycle dmem_ready rises in DWAIT is already evaluated as RUN.
    dwait_stall = (state_q == DWAIT) && !dmem_ready;
    dmem_stall  = dwait_stall || ((state_q != DWAIT) && dmem_req && !dmem_ready);
    redir_act   = ex_redirect || redirect_pend_q;
  end

  always_comb begin
    ctrl            = CTRL_RUN;
    state_d         = RUN;
    redirect_pend_d = redirect_pend_q;
    flush_inc       = 1'b0;
    if (dmem_stall) begin
      ctrl    = CTRL_FREEZE;
      state_d = DWAIT;
    end else if (redir_act) begin
      ctrl            = CTRL_REDIRECT;
      redirect_pend_d = !imem_ready;
      flush_inc       = !redirect_pend_q;
    end else if (load_use) begin
      ctrl = CTRL_LOAD_USE;
    end else if (!imem_ready) begin
      ctrl    = CTRL_IMISS;
      state_d = IWAIT;
    end
    if (!rst_n) begin
      ctrl = CTRL_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= RUN;
      redirect_pend_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      redirect_pend_q <= redirect_pend_d;
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_en    = ctrl.idex_en;
  assign idex_flush = ctrl.idex_flush;
  assign exmem_en   = ctrl.exmem_en;

  hazard_perf_counters #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_inc    (!ctrl.pc_en),
    .flush_inc    (flush_inc),
    .dwait_stall  (dwait_stall),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .dmem_timeout (dmem_timeout)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; control vector order is
// {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] C_RUN   = 6'b110101;
  localparam logic [5:0] C_FRZ   = 6'b000000;
  localparam logic [5:0] C_REDIR = 6'b111111;
  localparam logic [5:0] C_LU    = 6'b000111;
  localparam logic [5:0] C_IMISS = 6'b011101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic        imem_ready, dmem_req, dmem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic        dmem_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic [5:0]  ctl;

  int n_chk;
  int n_pass;

  always #5 clk = ~clk;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (5),
    .CNT_W      (32),
    .MAX_WAIT   (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .dmem_timeout (dmem_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic idle();
    rst_n       = 1'b1;
    id_rs1      = '0;
    id_rs2      = '0;
    ex_rd       = '0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    ex_mem_read = 1'b0;
    ex_redirect = 1'b0;
    imem_ready  = 1'b1;
    dmem_req    = 1'b0;
    dmem_ready  = 1'b1;
  endtask

  // Advance to the next negedge with idle inputs; caller then overrides.
  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
  endtask

  task automatic set_load_use();
    ex_rd       = 5'd5;
    ex_mem_read = 1'b1;
    id_rs1      = 5'd5;
    id_use_rs1  = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset overrides every hazard input.
    ex_redirect = 1'b1;
    set_load_use();
    dmem_req   = 1'b1;
    dmem_ready = 1'b0;
    imem_ready = 1'b0;
    #1 chk("rst_ctl", ctl, C_RUN);
    nxt();
    #1;
    chk("rst_ctl_after", ctl, C_RUN);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_timeout", dmem_timeout, 0);

    // Load-use bubbles
    nxt(); set_load_use();
    #1 chk("lu_rs1", ctl, C_LU);
    nxt();
    #1;
    chk("lu_clear", ctl, C_RUN);
    chk("lu_stall_cnt", stall_cnt, 1);
    nxt(); ex_rd = 5'd5; ex_mem_read = 1'b1; id_rs2 = 5'd5; id_use_rs2 = 1'b1; id_rs1 = 5'd7;
    #1 chk("lu_rs2", ctl, C_LU);
    nxt(); ex_rd = 5'd5; ex_mem_read = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd5;
    #1 chk("lu_nouse", ctl, C_RUN);
    nxt(); ex_rd = 5'd0; ex_mem_read = 1'b1; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    chk("lu_x0", ctl, C_RUN);
    chk("lu_x0_stall_cnt", stall_cnt, 2);
    nxt(); ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1 chk("lu_noload", ctl, C_RUN);

    // Redirect with fetch ready, then with fetch pending
    do_reset();
    nxt(); ex_redirect = 1'b1;
    #1 chk("redir", ctl, C_REDIR);
    nxt();
    #1;
    chk("redir_done", ctl, C_RUN);
    chk("redir_flush_cnt", flush_cnt, 1);
    do_reset();
    nxt(); ex_redirect = 1'b1; imem_ready = 1'b0;
    #1 chk("pend0", ctl, C_REDIR);
    nxt(); imem_ready = 1'b0;
    #1 chk("pend1", ctl, C_REDIR);
    nxt();
    #1 chk("pend2", ctl, C_REDIR);
    nxt();
    #1;
    chk("pend_done", ctl, C_RUN);
    chk("pend_flush_cnt", flush_cnt, 1);
    chk("pend_stall_cnt", stall_cnt, 0);

    // Fetch stall, then redirect beating a load-use
    nxt(); imem_ready = 1'b0;
    #1 chk("imiss1", ctl, C_IMISS);
    nxt(); imem_ready = 1'b0;
    #1 chk("imiss2", ctl, C_IMISS);
    nxt();
    #1;
    chk("imiss_done", ctl, C_RUN);
    chk("imiss_stall_cnt", stall_cnt, 2);
    nxt(); ex_redirect = 1'b1; set_load_use();
    #1 chk("redir_vs_lu", ctl, C_REDIR);
    nxt();
    #1;
    chk("redir_vs_lu_next", ctl, C_RUN);
    chk("redir_vs_lu_flush_cnt", flush_cnt, 2);

    // dmem freeze holding a redirect and a load-use
    do_reset();
    for (int i = 0; i < 4; i++) begin
      nxt(); dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1; set_load_use();
      #1 chk($sformatf("dfreeze%0d", i), ctl, C_FRZ);
    end
    nxt(); dmem_req = 1'b1; dmem_ready = 1'b1; ex_redirect = 1'b1; set_load_use();
    #1;
    chk("drelease", ctl, C_REDIR);
    chk("drelease_stall_cnt", stall_cnt, 4);
    chk("drelease_flush_cnt", flush_cnt, 0);
    nxt();
    #1;
    chk("dafter", ctl, C_RUN);
    chk("dafter_flush_cnt", flush_cnt, 1);
    chk("dafter_stall_cnt", stall_cnt, 4);

    // Timeout after the third DWAIT cycle, sticky past release
    do_reset();
    for (int i = 0; i < 5; i++) begin
      nxt(); dmem_req = 1'b1; dmem_ready = 1'b0;
      #1 chk($sformatf("to_cyc%0d", i), dmem_timeout, (i >= 4) ? 32'd1 : 32'd0);
    end
    nxt(); dmem_req = 1'b1; dmem_ready = 1'b1;
    #1;
    chk("to_release", dmem_timeout, 1);
    chk("to_release_ctl", ctl, C_RUN);
    nxt();
    #1 chk("to_sticky", dmem_timeout, 1);

    // Reset abandons DWAIT
    nxt(); dmem_req = 1'b1; dmem_ready = 1'b0;
    nxt(); dmem_req = 1'b1; dmem_ready = 1'b0;
    #1 chk("pre_rst_dwait", ctl, C_FRZ);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("rst_in_dwait", ctl, C_RUN);
    nxt();
    #1;
    chk("post_rst_ctl", ctl, C_RUN);
    chk("post_rst_stall_cnt", stall_cnt, 0);
    chk("post_rst_flush_cnt", flush_cnt, 0);
    chk("post_rst_timeout", dmem_timeout, 0);

    // Reset abandons a pending redirect
    nxt(); ex_redirect = 1'b1; imem_ready = 1'b0;
    #1 chk("pre_rst_pend", ctl, C_REDIR);
    do_reset();
    nxt();
    #1;
    chk("no_residual_flush", ctl, C_RUN);
    chk("no_residual_flush_cnt", flush_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
